// File: rtl/pwr_rail_sequencer.sv
// Generic power-rail sequencer: ramps rails up in index order with a pg timeout and
// settle delay, drops them in reverse order, and latches the first fault seen.
module pwr_rail_sequencer #(
   parameter int NUM_RAILS        = 8,
   parameter int IDX_W            = 3,
   parameter int TIMEOUT_CYCLES   = 65536,
   parameter int SETTLE_CYCLES    = 1024,
   parameter int OFF_DELAY_CYCLES = 256,
   parameter int CNT_W            = 17
) (
   input  logic                 osc_clk,
   input  logic                 rst,
   input  logic                 pwr_on_req,
   input  logic                 fault_clear,
   input  logic [NUM_RAILS-1:0] pg_in,
   output logic [NUM_RAILS-1:0] en_out,
   output logic                 all_good,
   output logic                 busy,
   output logic                 fault,
   output logic [IDX_W-1:0]     fault_rail,
   output logic [1:0]           fault_code
);
   typedef enum logic [2:0] {
      ST_OFF,
      ST_RAMP,
      ST_SETTLE,
      ST_ON,
      ST_SHUTDOWN,
      ST_FAULT
   } state_t;

   localparam logic [1:0]           CODE_NONE    = 2'b00;
   localparam logic [1:0]           CODE_TIMEOUT = 2'b01;
   localparam logic [1:0]           CODE_DROPOUT = 2'b10;
   localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   // Shutdown holds one extra cycle so successive disables are OFF_DELAY+1 apart.
   localparam logic [CNT_W-1:0]     OFF_LAST     = CNT_W'(OFF_DELAY_CYCLES);
   localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(NUM_RAILS - 1);
   localparam logic [NUM_RAILS-1:0] ALL_ON       = '1;

   state_t               state_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [NUM_RAILS-1:0] pg_meta_reg;
   logic [NUM_RAILS-1:0] pg_s_reg;
   logic [NUM_RAILS-1:0] en_reg;
   logic                 all_good_reg;
   logic                 busy_reg;
   logic                 fault_reg;
   logic [IDX_W-1:0]     fault_rail_reg;
   logic [1:0]           fault_code_reg;

   logic [NUM_RAILS-1:0] below_mask;
   logic [NUM_RAILS-1:0] upto_mask;
   logic [NUM_RAILS-1:0] drop_mask;
   logic [NUM_RAILS-1:0] drop_vec;
   logic [IDX_W-1:0]     drop_idx;
   logic                 fault_take;
   logic [1:0]           fault_take_code;
   logic [IDX_W-1:0]     fault_take_rail;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RAILS; gi++) begin : g_mask
         localparam logic [IDX_W:0] RAIL_NUM = (IDX_W + 1)'(gi);
         assign below_mask[gi] = RAIL_NUM <  {1'b0, idx_reg};
         assign upto_mask[gi]  = RAIL_NUM <= {1'b0, idx_reg};
      end
   endgenerate

   // Fault detection: dropout of an already-good rail outranks everything, then timeout.
   always_comb begin
      drop_mask = '0;
      case (state_reg)
         ST_RAMP:   drop_mask = below_mask;
         ST_SETTLE: drop_mask = upto_mask;
         ST_ON:     drop_mask = ALL_ON;
         default:   drop_mask = '0;
      endcase
      drop_vec = ~pg_s_reg & drop_mask;

      drop_idx = '0;
      for (int j = NUM_RAILS - 1; j >= 0; j--) begin
         if (drop_vec[j]) drop_idx = IDX_W'(j);
      end

      fault_take      = 1'b0;
      fault_take_code = CODE_NONE;
      fault_take_rail = '0;
      if (|drop_vec) begin
         fault_take      = 1'b1;
         fault_take_code = CODE_DROPOUT;
         fault_take_rail = drop_idx;
      end else if (state_reg == ST_RAMP && pwr_on_req && !pg_s_reg[idx_reg] &&
                   cnt_reg == TIMEOUT_LAST) begin
         fault_take      = 1'b1;
         fault_take_code = CODE_TIMEOUT;
         fault_take_rail = idx_reg;
      end
   end

   always_ff @(posedge osc_clk) begin
      if (rst) begin
         state_reg      <= ST_OFF;
         idx_reg        <= '0;
         cnt_reg        <= '0;
         pg_meta_reg    <= '0;
         pg_s_reg       <= '0;
         en_reg         <= '0;
         all_good_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         fault_reg      <= 1'b0;
         fault_rail_reg <= '0;
         fault_code_reg <= CODE_NONE;
      end else begin
         pg_meta_reg <= pg_in;
         pg_s_reg    <= pg_meta_reg;

         if (fault_take) begin
            state_reg      <= ST_FAULT;
            cnt_reg        <= '0;
            en_reg         <= '0;
            all_good_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            fault_reg      <= 1'b1;
            fault_rail_reg <= fault_take_rail;
            fault_code_reg <= fault_take_code;
         end else begin
            case (state_reg)
               ST_OFF: begin
                  en_reg <= '0;
                  if (pwr_on_req) begin
                     state_reg <= ST_RAMP;
                     idx_reg   <= '0;
                     cnt_reg   <= '0;
                     en_reg    <= NUM_RAILS'(1);
                     busy_reg  <= 1'b1;
                  end
               end

               ST_RAMP: begin
                  if (!pwr_on_req) begin
                     state_reg <= ST_SHUTDOWN;
                     cnt_reg   <= '0;
                     en_reg    <= en_reg >> 1;
                  end else if (pg_s_reg[idx_reg]) begin
                     state_reg <= ST_SETTLE;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end

               ST_SETTLE: begin
                  if (!pwr_on_req) begin
                     state_reg <= ST_SHUTDOWN;
                     cnt_reg   <= '0;
                     en_reg    <= en_reg >> 1;
                  end else if (cnt_reg == SETTLE_LAST) begin
                     cnt_reg <= '0;
                     if (idx_reg == LAST_IDX) begin
                        state_reg    <= ST_ON;
                        en_reg       <= ALL_ON;
                        all_good_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                     end else begin
                        state_reg <= ST_RAMP;
                        idx_reg   <= idx_reg + IDX_W'(1);
                        en_reg    <= (en_reg << 1) | NUM_RAILS'(1);
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end

               ST_ON: begin
                  if (!pwr_on_req) begin
                     state_reg    <= ST_SHUTDOWN;
                     idx_reg      <= LAST_IDX;
                     cnt_reg      <= '0;
                     en_reg       <= en_reg >> 1;
                     all_good_reg <= 1'b0;
                     busy_reg     <= 1'b1;
                  end
               end

               ST_SHUTDOWN: begin
                  if (cnt_reg == OFF_LAST) begin
                     cnt_reg <= '0;
                     if (idx_reg == '0) begin
                        state_reg <= ST_OFF;
                        busy_reg  <= 1'b0;
                     end else begin
                        idx_reg <= idx_reg - IDX_W'(1);
                        en_reg  <= en_reg >> 1;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end

               ST_FAULT: begin
                  // Clearing needs the request low as well, so a fault never auto-restarts.
                  if (fault_clear && !pwr_on_req) begin
                     state_reg      <= ST_OFF;
                     idx_reg        <= '0;
                     fault_reg      <= 1'b0;
                     fault_rail_reg <= '0;
                     fault_code_reg <= CODE_NONE;
                  end
               end

               default: begin
                  state_reg <= ST_OFF;
                  en_reg    <= '0;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign en_out     = en_reg;
   assign all_good   = all_good_reg;
   assign busy       = busy_reg;
   assign fault      = fault_reg;
   assign fault_rail = fault_rail_reg;
   assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_pwr_rail_sequencer.sv
// Scoreboard bench for pwr_rail_sequencer: a phase-level reference model predicts the
// outputs after every edge, a monitor compares them against the DUT one cycle at a time.
module tb_pwr_rail_sequencer;
   localparam int NR     = 4;
   localparam int IW     = 2;
   localparam int TMO    = 100;
   localparam int SETTLE = 10;
   localparam int OFFD   = 5;
   localparam int CW     = 8;

   localparam int M_OFF  = 0;
   localparam int M_UP   = 1;
   localparam int M_HOLD = 2;
   localparam int M_ON   = 3;
   localparam int M_DOWN = 4;
   localparam int M_FLT  = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          pwr_on_req;
   logic          fault_clear;
   logic [NR-1:0] pg_in;
   logic [NR-1:0] en_out;
   logic          all_good;
   logic          busy;
   logic          fault;
   logic [IW-1:0] fault_rail;
   logic [1:0]    fault_code;

   always #5 clk = ~clk;

   pwr_rail_sequencer #(
      .NUM_RAILS       (NR),
      .IDX_W           (IW),
      .TIMEOUT_CYCLES  (TMO),
      .SETTLE_CYCLES   (SETTLE),
      .OFF_DELAY_CYCLES(OFFD),
      .CNT_W           (CW)
   ) dut (
      .osc_clk    (clk),
      .rst        (rst),
      .pwr_on_req (pwr_on_req),
      .fault_clear(fault_clear),
      .pg_in      (pg_in),
      .en_out     (en_out),
      .all_good   (all_good),
      .busy       (busy),
      .fault      (fault),
      .fault_rail (fault_rail),
      .fault_code (fault_code)
   );

   typedef struct {
      logic [10:0] v;
      int          tag;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Stimulus intent, copied onto the DUT pins at each negedge.
   logic          req_v = 1'b0;
   logic          clr_v = 1'b0;
   logic          rst_v = 1'b1;
   logic [NR-1:0] dead  = '0;
   logic [NR-1:0] drop  = '0;
   int            dly[NR];
   int            on_cnt[NR];

   // Reference model: phase, active rail, and the edge number at which the phase began.
   int            cyc    = 0;
   int            m_mode = M_OFF;
   int            m_n    = 0;
   int            m_mark = 0;
   logic          m_fault = 1'b0;
   logic [1:0]    m_fr   = '0;
   logic [1:0]    m_fc   = '0;
   logic [NR-1:0] m1     = '0;
   logic [NR-1:0] m2     = '0;

   function automatic string tag_name(input int t);
      case (t)
         0:       return "reset";
         1:       return "nominal";
         2:       return "shutdown";
         3:       return "timeout";
         4:       return "fault_clear";
         5:       return "dropout";
         6:       return "reset_mid";
         default: return "random";
      endcase
   endfunction

   function automatic logic [NR-1:0] model_en();
      case (m_mode)
         M_UP, M_HOLD: return NR'((1 << (m_n + 1)) - 1);
         M_ON:         return '1;
         M_DOWN:       return NR'((1 << m_n) - 1);
         default:      return '0;
      endcase
   endfunction

   function automatic logic [10:0] model_vec();
      logic ag;
      logic bs;
      ag = (m_mode == M_ON);
      bs = (m_mode == M_UP) || (m_mode == M_HOLD) || (m_mode == M_DOWN);
      return {model_en(), ag, bs, m_fault, m_fr, m_fc};
   endfunction

   function automatic int lowest_low(input logic [NR-1:0] ps, input int upto);
      for (int j = 0; j < upto; j++) begin
         if (!ps[j]) return j;
      end
      return -1;
   endfunction

   task automatic go_fault(input logic [1:0] code, input int rail);
      m_mode  = M_FLT;
      m_fault = 1'b1;
      m_fc    = code;
      m_fr    = IW'(rail);
   endtask

   task automatic model_step();
      logic [NR-1:0] ps;
      int            low;
      cyc++;
      if (rst) begin
         m_mode = M_OFF; m_n = 0; m_mark = cyc;
         m_fault = 1'b0; m_fr = '0; m_fc = '0;
         m1 = '0; m2 = '0;
      end else begin
         ps = m2;
         case (m_mode)
            M_OFF: if (pwr_on_req) begin m_mode = M_UP; m_n = 0; m_mark = cyc; end
            M_UP: begin
               low = lowest_low(ps, m_n);
               if (low >= 0)                 go_fault(2'b10, low);
               else if (!pwr_on_req)         begin m_mode = M_DOWN; m_mark = cyc; end
               else if (ps[m_n])             begin m_mode = M_HOLD; m_mark = cyc; end
               else if (cyc - m_mark == TMO) go_fault(2'b01, m_n);
            end
            M_HOLD: begin
               low = lowest_low(ps, m_n + 1);
               if (low >= 0)         go_fault(2'b10, low);
               else if (!pwr_on_req) begin m_mode = M_DOWN; m_mark = cyc; end
               else if (cyc - m_mark == SETTLE) begin
                  if (m_n == NR - 1) m_mode = M_ON;
                  else begin m_n++; m_mode = M_UP; end
                  m_mark = cyc;
               end
            end
            M_ON: begin
               low = lowest_low(ps, NR);
               if (low >= 0)         go_fault(2'b10, low);
               else if (!pwr_on_req) begin m_mode = M_DOWN; m_n = NR - 1; m_mark = cyc; end
            end
            M_DOWN: begin
               if (cyc - m_mark == OFFD + 1) begin
                  if (m_n == 0) m_mode = M_OFF;
                  else m_n--;
                  m_mark = cyc;
               end
            end
            default: begin
               if (fault_clear && !pwr_on_req) begin
                  m_mode = M_OFF; m_n = 0;
                  m_fault = 1'b0; m_fr = '0; m_fc = '0;
               end
            end
         endcase
         m2 = m1;
         m1 = pg_in;
      end
   endtask

   // One cycle: plant raises pg a per-rail delay after its enable, then the model steps.
   task automatic tick(input int tag);
      logic [NR-1:0] en_now;
      logic [NR-1:0] pg_v;
      exp_t          e;
      @(negedge clk);
      en_now = model_en();
      for (int i = 0; i < NR; i++) begin
         on_cnt[i] = en_now[i] ? on_cnt[i] + 1 : 0;
         pg_v[i]   = en_now[i] && !dead[i] && !drop[i] && (on_cnt[i] >= dly[i]);
      end
      pg_in       = pg_v;
      pwr_on_req  = req_v;
      fault_clear = clr_v;
      rst         = rst_v;
      model_step();
      e.v   = model_vec();
      e.tag = tag;
      e.cyc = cyc;
      sb_q.push_back(e);
   endtask

   task automatic run_until(input int mode_want, input int n_want, input int limit,
                            input int tag);
      int k;
      k = 0;
      while (!(m_mode == mode_want && (n_want < 0 || m_n == n_want)) && k < limit) begin
         tick(tag);
         k++;
      end
      if (!(m_mode == mode_want && (n_want < 0 || m_n == n_want))) begin
         vectors++;
         miscompares++;
         $display("FAIL %s wait: phase %0d not reached within %0d cycles (now phase %0d)",
                  tag_name(tag), mode_want, limit, m_mode);
      end
   endtask

   // Monitor: one popped expectation per clock, compared 1 time unit after the edge.
   initial begin
      exp_t        e;
      logic [10:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {en_out, all_good, busy, fault, fault_rail, fault_code};
            vectors++;
            if (got !== e.v) begin
               miscompares++;
               $display("FAIL %s cycle %0d: got en=%b good=%b busy=%b fault=%b rail=%0d code=%b, required en=%b good=%b busy=%b fault=%b rail=%0d code=%b",
                        tag_name(e.tag), e.cyc, got[10:7], got[6], got[5], got[4],
                        got[3:2], got[1:0], e.v[10:7], e.v[6], e.v[5], e.v[4],
                        e.v[3:2], e.v[1:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; pwr_on_req = 1'b0; fault_clear = 1'b0; pg_in = '0;
      for (int i = 0; i < NR; i++) begin dly[i] = 4; on_cnt[i] = 0; end

      rst_v = 1'b1;
      repeat (3) tick(0);
      rst_v = 1'b0;
      repeat (2) tick(0);

      req_v = 1'b1;
      run_until(M_ON, -1, 100, 1);
      repeat (10) tick(1);

      req_v = 1'b0;
      run_until(M_OFF, -1, 40, 2);
      repeat (3) tick(2);

      dead[2] = 1'b1;
      req_v   = 1'b1;
      run_until(M_FLT, -1, 200, 3);
      repeat (5) tick(3);

      clr_v = 1'b1; tick(4); clr_v = 1'b0;
      repeat (4) tick(4);
      req_v = 1'b0;
      repeat (2) tick(4);
      clr_v = 1'b1; tick(4); clr_v = 1'b0;
      repeat (2) tick(4);
      dead[2] = 1'b0;
      req_v   = 1'b1;
      run_until(M_ON, -1, 100, 4);
      repeat (5) tick(4);

      drop[1] = 1'b1;
      drop[3] = 1'b1;
      run_until(M_FLT, -1, 10, 5);
      repeat (4) tick(5);
      req_v = 1'b0; clr_v = 1'b1; tick(5); clr_v = 1'b0;
      drop  = '0;
      repeat (2) tick(5);

      req_v = 1'b1;
      run_until(M_HOLD, 1, 100, 6);
      repeat (3) tick(6);
      rst_v = 1'b1; tick(6); rst_v = 1'b0;
      dead[1] = 1'b1;
      run_until(M_FLT, -1, 300, 6);
      repeat (2) tick(6);
      rst_v = 1'b1; tick(6); rst_v = 1'b0;
      req_v = 1'b0;
      repeat (3) tick(6);
      dead[1] = 1'b0;

      for (int k = 0; k < 2500; k++) begin
         int r;
         if ($urandom_range(0, 149) == 0) req_v = ~req_v;
         clr_v = ($urandom_range(0, 24) == 0);
         rst_v = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 119) == 0) begin
            r       = $urandom_range(0, NR - 1);
            drop[r] = ~drop[r];
         end
         if (m_mode == M_OFF && $urandom_range(0, 9) == 0) begin
            for (int i = 0; i < NR; i++) begin
               dly[i]  = $urandom_range(1, 8);
               dead[i] = ($urandom_range(0, 11) == 0);
            end
         end
         tick(7);
      end
      rst_v = 1'b0; clr_v = 1'b0; req_v = 1'b0;
      repeat (3) tick(7);

      @(posedge clk);
      #3;
      if (sb_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
